input_arbiter_rr: RTL and testbench

INPUT_ARBITER_RR -- requirements
Module: input_arbiter_rr

---
 rtl/nf_arb_pkg.sv | 27 ++
 rtl/input_arbiter_rr_if.sv | 33 +++
 rtl/arb_in_fifo.sv | 58 +++++
 rtl/input_arbiter_rr.sv | 149 ++++++++++++++
 tb/tb_input_arbiter_rr.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nf_arb_pkg.sv
// Shared definitions for the input arbiter: FSM encoding, arbitration
// policy codes and a constant ceiling-log2 helper.
package nf_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Ceiling log2, usable in parameter expressions.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/input_arbiter_rr_if.sv
// Bundles the per-port input bus, the output bus and the status counters
// of the input arbiter; slave is the arbiter's view, master the driver's.
interface input_arbiter_rr_if
    import nf_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = (log2(NUM_PORTS) > 1) ? log2(NUM_PORTS) : 1
);
    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS*CTRL_WIDTH-1:0] in_ctrl;
    logic [NUM_PORTS-1:0]            in_wr;
    logic [NUM_PORTS-1:0]            in_rdy;
    logic [NUM_PORTS-1:0]            port_en;
    logic [DATA_WIDTH-1:0]           out_data;
    logic [CTRL_WIDTH-1:0]           out_ctrl;
    logic                            out_wr;
    logic                            out_rdy;
    logic [PORT_W-1:0]               cur_port;
    logic [31:0]                     pkt_count;
    logic [15:0]                     drop_count;

    modport slave (
        input  in_data, in_ctrl, in_wr, port_en, out_rdy,
        output in_rdy, out_data, out_ctrl, out_wr, cur_port, pkt_count, drop_count
    );

    modport master (
        output in_data, in_ctrl, in_wr, port_en, out_rdy,
        input  in_rdy, out_data, out_ctrl, out_wr, cur_port, pkt_count, drop_count
    );
endinterface

// File: rtl/arb_in_fifo.sv
// Per-port show-ahead FIFO; a push on a full FIFO succeeds only when a pop
// frees an entry in the same cycle.
module arb_in_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             nearly_full_o
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q;
    logic [DEPTH_BITS-1:0] rd_ptr_q;
    logic [DEPTH_BITS:0]   count_q;
    logic                  push_s;
    logic                  pop_s;

    assign empty_o       = (count_q == {(DEPTH_BITS+1){1'b0}});
    assign full_o        = (count_q == (DEPTH_BITS+1)'(DEPTH));
    assign nearly_full_o = (count_q >= (DEPTH_BITS+1)'(DEPTH - 1));
    assign pop_s         = rd_en_i && !empty_o;
    assign push_s        = wr_en_i && (!full_o || pop_s);
    assign dout_o        = mem_q[rd_ptr_q];

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {DEPTH_BITS{1'b0}};
            rd_ptr_q <= {DEPTH_BITS{1'b0}};
            count_q  <= {(DEPTH_BITS+1){1'b0}};
        end else begin
            if (push_s) wr_ptr_q <= wr_ptr_q + DEPTH_BITS'(1);
            if (pop_s)  rd_ptr_q <= rd_ptr_q + DEPTH_BITS'(1);
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + (DEPTH_BITS+1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_BITS+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/input_arbiter_rr.sv
// Packet-granular input arbiter: buffers each input port in its own FIFO and
// forwards whole packets, one port at a time, onto a single output bus.
module input_arbiter_rr
    import nf_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int NUM_PORTS       = 4,
    parameter int FIFO_DEPTH_BITS = 3,
    parameter int ARB_MODE        = ARB_RR
) (
    input  logic              clk,
    input  logic              reset,
    input_arbiter_rr_if.slave bus
);
    localparam int PORT_W = (log2(NUM_PORTS) > 1) ? log2(NUM_PORTS) : 1;
    localparam int WORD_W = CTRL_WIDTH + DATA_WIDTH;

    arb_state_e            state_q;
    logic [PORT_W-1:0]     cur_port_q;
    logic                  in_payload_q;
    logic                  out_wr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;
    logic [31:0]           pkt_count_q;
    logic [15:0]           drop_count_q;
    logic [15:0]           drop_count_d;

    logic [NUM_PORTS-1:0]  empty_s, full_s, nearly_full_s, rd_en_s, drop_s, eligible_s;
    logic [WORD_W-1:0]     fifo_dout_s [NUM_PORTS];
    logic [WORD_W-1:0]     head_s;
    logic [CTRL_WIDTH-1:0] head_ctrl_s;
    logic                  pop_s;
    logic                  grant_valid_s;
    logic [PORT_W-1:0]     grant_idx_s;
    logic [4:0]            drop_num_s;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        arb_in_fifo #(
            .WIDTH      (WORD_W),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk           (clk),
            .reset         (reset),
            .wr_en_i       (bus.in_wr[g]),
            .din_i         ({bus.in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH],
                             bus.in_data[g*DATA_WIDTH +: DATA_WIDTH]}),
            .rd_en_i       (rd_en_s[g]),
            .dout_o        (fifo_dout_s[g]),
            .empty_o       (empty_s[g]),
            .full_o        (full_s[g]),
            .nearly_full_o (nearly_full_s[g])
        );
        assign rd_en_s[g] = pop_s && (cur_port_q == PORT_W'(g));
        assign drop_s[g]  = bus.in_wr[g] && full_s[g] && !rd_en_s[g];
    end

    assign eligible_s  = bus.port_en & ~empty_s;
    assign head_s      = fifo_dout_s[cur_port_q];
    assign head_ctrl_s = head_s[WORD_W-1 -: CTRL_WIDTH];
    assign pop_s       = (state_q == ST_XFER) && bus.out_rdy && !empty_s[cur_port_q];

    // Grant selection; loops run far-to-near so the preferred port is written last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = cur_port_q;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (eligible_s[i]) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = PORT_W'(i);
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end else begin
            for (int k = NUM_PORTS; k >= 1; k--) begin
                if (eligible_s[PORT_W'((int'(cur_port_q) + k) % NUM_PORTS)]) begin
                    grant_valid_s = 1'b1;
                    grant_idx_s   = PORT_W'((int'(cur_port_q) + k) % NUM_PORTS);
                end else begin
                    grant_valid_s = grant_valid_s;
                end
            end
        end
    end

    // Several ports can drop in one cycle; the counter saturates.
    always_comb begin
        drop_num_s = 5'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            drop_num_s = drop_num_s + {4'd0, drop_s[i]};
        end
        if (({1'b0, drop_count_q} + {12'd0, drop_num_s}) > 17'h0FFFF) begin
            drop_count_d = 16'hFFFF;
        end else begin
            drop_count_d = drop_count_q + {11'd0, drop_num_s};
        end
    end

    // Arbiter FSM with registered output bus and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cur_port_q   <= PORT_W'(NUM_PORTS - 1);
            in_payload_q <= 1'b0;
            out_wr_q     <= 1'b0;
            out_data_q   <= {DATA_WIDTH{1'b0}};
            out_ctrl_q   <= {CTRL_WIDTH{1'b0}};
            pkt_count_q  <= 32'd0;
            drop_count_q <= 16'd0;
        end else begin
            drop_count_q <= drop_count_d;
            out_wr_q     <= pop_s;
            if (pop_s) begin
                out_data_q <= head_s[DATA_WIDTH-1:0];
                out_ctrl_q <= head_ctrl_s;
            end
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        cur_port_q <= grant_idx_s;
                        state_q    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (pop_s) begin
                        if (head_ctrl_s == {CTRL_WIDTH{1'b0}}) begin
                            in_payload_q <= 1'b1;
                        end else if (in_payload_q) begin
                            in_payload_q <= 1'b0;
                            pkt_count_q  <= pkt_count_q + 32'd1;
                            state_q      <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_rdy     = ~nearly_full_s;
    assign bus.out_wr     = out_wr_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_ctrl   = out_ctrl_q;
    assign bus.cur_port   = cur_port_q;
    assign bus.pkt_count  = pkt_count_q;
    assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_input_arbiter_rr.sv
// Scoreboard bench for input_arbiter_rr: a round-robin instance checked by a
// free-running output monitor, plus a fixed-priority instance.
module tb_input_arbiter_rr;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   mon_words;
    logic mon_last_rdy;
    logic mon_payload;
    logic mon_eop_prev;
    logic [71:0] exp_q [$];
    logic [71:0] exp_fp_q [$];

    input_arbiter_rr_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_PORTS(4)) bus_rr ();
    input_arbiter_rr_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_PORTS(4)) bus_fp ();

    input_arbiter_rr #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_PORTS(4),
                       .FIFO_DEPTH_BITS(3), .ARB_MODE(0))
        dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));

    input_arbiter_rr #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .NUM_PORTS(4),
                       .FIFO_DEPTH_BITS(3), .ARB_MODE(1))
        dut_fp (.clk(clk), .reset(reset), .bus(bus_fp));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [71:0] make_word(input int p, input int pkt, input int w);
        logic [7:0] c;
        if (w == 0) c = 8'hFF;
        else if (w == 3) c = 8'h01;
        else c = 8'h00;
        return {c, 8'(p), 8'(pkt), 8'(w), 40'hC0_FFEE_0000};
    endfunction

    // Output-rdy history for the monitor.
    initial forever begin
        @(posedge clk);
        mon_last_rdy = bus_rr.out_rdy;
    end

    // Scoreboard monitor for the round-robin instance.
    initial begin
        logic [71:0] e;
        mon_payload  = 1'b0;
        mon_eop_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                mon_payload  = 1'b0;
                mon_eop_prev = 1'b0;
            end else begin
                if (mon_eop_prev) begin
                    checks++;
                    if (bus_rr.out_wr !== 1'b0) begin
                        errors++;
                        $display("FAIL pkt_gap: out_wr=%b required 0 right after end of packet", bus_rr.out_wr);
                    end
                end
                mon_eop_prev = 1'b0;
                if (bus_rr.out_wr === 1'b1) begin
                    mon_words++;
                    checks++;
                    if (mon_last_rdy !== 1'b1) begin
                        errors++;
                        $display("FAIL rdy_gate: out_wr=1 after cycle with out_rdy=%b required 1", mon_last_rdy);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word: got %h required none", {bus_rr.out_ctrl, bus_rr.out_data});
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus_rr.out_ctrl, bus_rr.out_data} !== e) begin
                            errors++;
                            $display("FAIL out_word: got %h required %h", {bus_rr.out_ctrl, bus_rr.out_data}, e);
                        end
                    end
                    if (bus_rr.out_ctrl == 8'h00) begin
                        mon_payload = 1'b1;
                    end else if (mon_payload) begin
                        mon_payload  = 1'b0;
                        mon_eop_prev = 1'b1;
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus_rr.in_wr = 4'h0; bus_rr.port_en = 4'h0; bus_rr.out_rdy = 1'b0;
        bus_fp.in_wr = 4'h0; bus_fp.port_en = 4'h0; bus_fp.out_rdy = 1'b0;
        exp_q.delete();
        exp_fp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mon_words = 0;
    endtask

    task automatic drive_word(input bit fp, input int p, input logic [71:0] w);
        @(posedge clk); #1;
        if (fp) begin
            bus_fp.in_wr = 4'h0;
            bus_fp.in_wr[p] = 1'b1;
            bus_fp.in_data[p*64 +: 64] = w[63:0];
            bus_fp.in_ctrl[p*8 +: 8] = w[71:64];
        end else begin
            bus_rr.in_wr = 4'h0;
            bus_rr.in_wr[p] = 1'b1;
            bus_rr.in_data[p*64 +: 64] = w[63:0];
            bus_rr.in_ctrl[p*8 +: 8] = w[71:64];
        end
    endtask

    task automatic drive_idle();
        @(posedge clk); #1;
        bus_rr.in_wr = 4'h0;
        bus_fp.in_wr = 4'h0;
    endtask

    task automatic send_pkt(input bit fp, input int p, input int pkt, input bit push);
        for (int w = 0; w < 4; w++) begin
            drive_word(fp, p, make_word(p, pkt, w));
            if (push) exp_q.push_back(make_word(p, pkt, w));
        end
        drive_idle();
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus_rr.out_wr !== 1'b0) begin errors++; $display("FAIL rst_out_wr: got %b required 0", bus_rr.out_wr); end
        checks++; if (bus_rr.out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data: got %h required 0", bus_rr.out_data); end
        checks++; if (bus_rr.out_ctrl !== 8'h0) begin errors++; $display("FAIL rst_out_ctrl: got %h required 0", bus_rr.out_ctrl); end
        checks++; if (bus_rr.cur_port !== 2'd3) begin errors++; $display("FAIL rst_cur_port: got %0d required 3", bus_rr.cur_port); end
        checks++; if (bus_fp.cur_port !== 2'd3) begin errors++; $display("FAIL rst_cur_port_fp: got %0d required 3", bus_fp.cur_port); end
        checks++; if (bus_rr.pkt_count !== 32'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d required 0", bus_rr.pkt_count); end
        checks++; if (bus_rr.drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop_count: got %0d required 0", bus_rr.drop_count); end
        checks++; if (bus_rr.in_rdy !== 4'hF) begin errors++; $display("FAIL rst_in_rdy: got %b required 1111", bus_rr.in_rdy); end
    endtask

    task automatic test_single_port();
        bit ok;
        do_reset();
        bus_rr.port_en = 4'hF;
        bus_rr.out_rdy = 1'b1;
        for (int k = 0; k < 3; k++) send_pkt(1'b0, 0, k, 1'b1);
        wait_drain(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_drain: %0d words left required 0", exp_q.size()); end
        checks++; if (mon_words != 12) begin errors++; $display("FAIL single_words: got %0d required 12", mon_words); end
        checks++; if (bus_rr.pkt_count !== 32'd3) begin errors++; $display("FAIL single_pkt_count: got %0d required 3", bus_rr.pkt_count); end
    endtask

    task automatic test_round_robin();
        bit ok;
        bit seen2;
        int order [3] = '{0, 1, 3};
        do_reset();
        bus_rr.port_en = 4'hF;
        for (int pkt = 0; pkt < 2; pkt++)
            for (int j = 0; j < 3; j++) send_pkt(1'b0, order[j], pkt, 1'b1);
        bus_rr.out_rdy = 1'b1;
        ok = 1'b0;
        seen2 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_rr.cur_port == 2'd2) seen2 = 1'b1;
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL rr_drain: %0d words left required 0", exp_q.size()); end
        checks++; if (seen2) begin errors++; $display("FAIL rr_port2: port 2 granted=1 required 0"); end
        checks++; if (bus_rr.pkt_count !== 32'd6) begin errors++; $display("FAIL rr_pkt_count: got %0d required 6", bus_rr.pkt_count); end
        checks++; if (bus_rr.cur_port !== 2'd3) begin errors++; $display("FAIL rr_last_port: got %0d required 3", bus_rr.cur_port); end
    endtask

    task automatic test_fixed_prio();
        bit ok;
        logic [71:0] e;
        do_reset();
        send_pkt(1'b1, 2, 0, 1'b0);
        send_pkt(1'b1, 1, 0, 1'b0);
        send_pkt(1'b1, 2, 1, 1'b0);
        send_pkt(1'b1, 1, 1, 1'b0);
        for (int w = 0; w < 4; w++) exp_fp_q.push_back(make_word(1, 0, w));
        for (int w = 0; w < 4; w++) exp_fp_q.push_back(make_word(1, 1, w));
        for (int w = 0; w < 4; w++) exp_fp_q.push_back(make_word(2, 0, w));
        for (int w = 0; w < 4; w++) exp_fp_q.push_back(make_word(2, 1, w));
        bus_fp.port_en = 4'hF;
        bus_fp.out_rdy = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus_fp.out_wr === 1'b1) begin
                checks++;
                if (exp_fp_q.size() == 0) begin
                    errors++;
                    $display("FAIL fp_unexpected: got %h required none", {bus_fp.out_ctrl, bus_fp.out_data});
                end else begin
                    e = exp_fp_q.pop_front();
                    if ({bus_fp.out_ctrl, bus_fp.out_data} !== e) begin
                        errors++;
                        $display("FAIL fp_word: got %h required %h", {bus_fp.out_ctrl, bus_fp.out_data}, e);
                    end
                end
            end
            if (exp_fp_q.size() == 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL fp_drain: %0d words left required 0", exp_fp_q.size()); end
        checks++; if (bus_fp.pkt_count !== 32'd4) begin errors++; $display("FAIL fp_pkt_count: got %0d required 4", bus_fp.pkt_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus_rr.port_en = 4'hF;
        send_pkt(1'b0, 0, 0, 1'b1);
        send_pkt(1'b0, 0, 1, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            bus_rr.out_rdy = ~bus_rr.out_rdy;
            if (exp_q.size() == 0) break;
        end
        bus_rr.out_rdy = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain: %0d words left required 0", exp_q.size()); end
        checks++; if (mon_words != 8) begin errors++; $display("FAIL bp_words: got %0d required 8", mon_words); end
        checks++; if (bus_rr.pkt_count !== 32'd2) begin errors++; $display("FAIL bp_pkt_count: got %0d required 2", bus_rr.pkt_count); end
    endtask

    task automatic test_drop();
        bit ok;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            bus_rr.in_wr = 4'b0100;
            bus_rr.in_data[2*64 +: 64] = make_word(2, k / 4, k % 4) >> 0;
            bus_rr.in_ctrl[2*8 +: 8] = make_word(2, k / 4, k % 4) >> 64;
            if (k < 8) exp_q.push_back(make_word(2, k / 4, k % 4));
            @(negedge clk);
            if (k > 0) begin
                checks++;
                if (bus_rr.in_rdy[2] !== (k <= 6)) begin
                    errors++;
                    $display("FAIL drop_in_rdy: after %0d writes got %b required %b", k, bus_rr.in_rdy[2], (k <= 6));
                end
            end
        end
        @(posedge clk); #1;
        bus_rr.in_wr = 4'h0;
        @(negedge clk);
        checks++; if (bus_rr.in_rdy[2] !== 1'b0) begin errors++; $display("FAIL drop_in_rdy_full: got %b required 0", bus_rr.in_rdy[2]); end
        checks++; if (bus_rr.drop_count !== 16'd2) begin errors++; $display("FAIL drop_count: got %0d required 2", bus_rr.drop_count); end
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            bus_rr.in_wr = 4'b1010;
        end
        @(posedge clk); #1;
        bus_rr.in_wr = 4'h0;
        @(negedge clk);
        checks++; if (bus_rr.drop_count !== 16'd4) begin errors++; $display("FAIL drop_count_multi: got %0d required 4", bus_rr.drop_count); end
        bus_rr.port_en = 4'b0100;
        bus_rr.out_rdy = 1'b1;
        wait_drain(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_drain: %0d words left required 0", exp_q.size()); end
        checks++; if (bus_rr.pkt_count !== 32'd2) begin errors++; $display("FAIL drop_pkt_count: got %0d required 2", bus_rr.pkt_count); end
    endtask

    task automatic test_port_en_mid();
        bit ok;
        do_reset();
        bus_rr.port_en = 4'hF;
        send_pkt(1'b0, 1, 0, 1'b1);
        bus_rr.out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus_rr.port_en = 4'b1101;
        send_pkt(1'b0, 1, 1, 1'b0);
        send_pkt(1'b0, 0, 0, 1'b1);
        wait_drain(100, ok);
        repeat (30) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL en_drain: %0d words left required 0", exp_q.size()); end
        checks++; if (mon_words != 8) begin errors++; $display("FAIL en_words: got %0d required 8", mon_words); end
        checks++; if (bus_rr.pkt_count !== 32'd2) begin errors++; $display("FAIL en_pkt_count: got %0d required 2", bus_rr.pkt_count); end
        checks++; if (bus_rr.cur_port !== 2'd0) begin errors++; $display("FAIL en_cur_port: got %0d required 0", bus_rr.cur_port); end
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        do_reset();
        bus_rr.port_en = 4'hF;
        send_pkt(1'b0, 0, 0, 1'b1);
        bus_rr.out_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_rr.out_wr !== 1'b0) wr_seen++;
        end
        checks++; if (wr_seen != 0) begin errors++; $display("FAIL rstmid_out_wr: got %0d words required 0", wr_seen); end
        checks++; if (bus_rr.in_rdy !== 4'hF) begin errors++; $display("FAIL rstmid_in_rdy: got %b required 1111", bus_rr.in_rdy); end
        checks++; if (bus_rr.pkt_count !== 32'd0) begin errors++; $display("FAIL rstmid_pkt_count: got %0d required 0", bus_rr.pkt_count); end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        mon_words = 0;
        mon_last_rdy = 1'b0;
        reset = 1'b1;
        bus_rr.in_data = '0; bus_rr.in_ctrl = '0; bus_rr.in_wr = '0; bus_rr.port_en = '0; bus_rr.out_rdy = 1'b0;
        bus_fp.in_data = '0; bus_fp.in_ctrl = '0; bus_fp.in_wr = '0; bus_fp.port_en = '0; bus_fp.out_rdy = 1'b0;
        test_reset();
        test_single_port();
        test_round_robin();
        test_fixed_prio();
        test_backpressure();
        test_drop();
        test_port_en_mid();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
